// File: rtl/my_tb_pkg.sv
// ============================================================================
// Module      : my_tb_pkg
// Description : Shared types and default parameters for the reset sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package my_tb_pkg;

  typedef enum logic [1:0] {
    S_RESET   = 2'd0,
    S_HOLD    = 2'd1,
    S_RELEASE = 2'd2,
    S_DONE    = 2'd3
  } rst_seq_state_e;

  localparam int C_DEF_SYNC_STAGES = 2;
  localparam int C_DEF_HOLD_CYCLES = 16;
  localparam int C_DEF_GAP_CYCLES  = 4;
  localparam int C_DEF_NUM_STAGES  = 3;

endpackage

`default_nettype wire

// File: rtl/my_reset_sync.sv
// ============================================================================
// Module      : my_reset_sync
// Description : Asynchronous-assert, synchronous-deassert reset synchroniser.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module my_reset_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  output logic rst_sync
);

  logic [SYNC_STAGES-1:0] r_sync;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync <= '1;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], 1'b0};
    end
  end

  assign rst_sync = r_sync[SYNC_STAGES-1];

endmodule

`default_nettype wire

// File: rtl/my_reset_sequencer.sv
// ============================================================================
// Module      : my_reset_sequencer
// Description : Synchronises raw reset, holds, then releases reset domains in
//               order with a fixed gap; soft reset replays the sequence.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module my_reset_sequencer
  import my_tb_pkg::*;
#(
  parameter int SYNC_STAGES = C_DEF_SYNC_STAGES,
  parameter int HOLD_CYCLES = C_DEF_HOLD_CYCLES,
  parameter int GAP_CYCLES  = C_DEF_GAP_CYCLES,
  parameter int NUM_STAGES  = C_DEF_NUM_STAGES
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              sw_rst_req,
  output logic [NUM_STAGES-1:0]             stage_rst_n,
  output logic                              rst_done,
  output logic                              busy,
  output logic [$clog2(NUM_STAGES+1)-1:0]   cur_stage
);

  localparam int C_CNT_MAX = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int C_CNT_W   = $clog2(C_CNT_MAX + 1);
  localparam int C_STG_W   = $clog2(NUM_STAGES + 1);

  localparam logic [C_CNT_W-1:0]    C_HOLD_LAST  = C_CNT_W'(HOLD_CYCLES - 1);
  localparam logic [C_CNT_W-1:0]    C_GAP_LAST   = C_CNT_W'(GAP_CYCLES - 1);
  localparam logic [C_CNT_W-1:0]    C_CNT_ONE    = C_CNT_W'(1);
  localparam logic [C_STG_W-1:0]    C_STG_ONE    = C_STG_W'(1);
  localparam logic [C_STG_W-1:0]    C_LAST_STAGE = C_STG_W'(NUM_STAGES - 1);
  localparam logic [NUM_STAGES-1:0] C_LSB        = NUM_STAGES'(1);

  if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_chk_sync
    $error("SYNC_STAGES must be in 2..4");
  end
  if (HOLD_CYCLES < 1) begin : g_chk_hold
    $error("HOLD_CYCLES must be at least 1");
  end
  if (GAP_CYCLES < 1) begin : g_chk_gap
    $error("GAP_CYCLES must be at least 1");
  end
  if (NUM_STAGES < 1 || NUM_STAGES > 8) begin : g_chk_num
    $error("NUM_STAGES must be in 1..8");
  end

  logic                  w_rst_sync;
  rst_seq_state_e        r_state, w_state;
  logic [C_CNT_W-1:0]    r_cnt, w_cnt;
  logic [NUM_STAGES-1:0] r_stage_rst_n, w_stage_rst_n;
  logic [C_STG_W-1:0]    r_cur_stage, w_cur_stage;
  logic                  r_rst_done, w_rst_done;
  logic                  r_busy, w_busy;

  my_reset_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_reset_sync (
    .clk      (clk),
    .rst      (rst),
    .rst_sync (w_rst_sync)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= S_RESET;
      r_cnt         <= '0;
      r_stage_rst_n <= '0;
      r_cur_stage   <= '0;
      r_rst_done    <= 1'b0;
      r_busy        <= 1'b1;
    end else begin
      r_state       <= w_state;
      r_cnt         <= w_cnt;
      r_stage_rst_n <= w_stage_rst_n;
      r_cur_stage   <= w_cur_stage;
      r_rst_done    <= w_rst_done;
      r_busy        <= w_busy;
    end
  end

  always_comb begin
    w_state       = r_state;
    w_cnt         = r_cnt;
    w_stage_rst_n = r_stage_rst_n;
    w_cur_stage   = r_cur_stage;
    w_rst_done    = r_rst_done;
    w_busy        = r_busy;

    case (r_state)
      S_RESET: begin
        if (!w_rst_sync) begin
          w_state = S_HOLD;
          w_cnt   = '0;
        end
      end
      S_HOLD: begin
        if (r_cnt == C_HOLD_LAST) begin
          w_stage_rst_n = (r_stage_rst_n << 1) | C_LSB;
          w_cur_stage   = r_cur_stage + C_STG_ONE;
          w_cnt         = '0;
          if (NUM_STAGES == 1) begin
            w_state    = S_DONE;
            w_rst_done = 1'b1;
            w_busy     = 1'b0;
          end else begin
            w_state = S_RELEASE;
          end
        end else begin
          w_cnt = r_cnt + C_CNT_ONE;
        end
      end
      S_RELEASE: begin
        if (r_cnt == C_GAP_LAST) begin
          // Releases are a thermometer code, so shifting in a 1 frees the next domain.
          w_stage_rst_n = (r_stage_rst_n << 1) | C_LSB;
          w_cur_stage   = r_cur_stage + C_STG_ONE;
          w_cnt         = '0;
          if (r_cur_stage == C_LAST_STAGE) begin
            w_state    = S_DONE;
            w_rst_done = 1'b1;
            w_busy     = 1'b0;
          end
        end else begin
          w_cnt = r_cnt + C_CNT_ONE;
        end
      end
      default: begin
        w_state = S_DONE;
      end
    endcase

    // Soft reset outranks any release due on the same edge.
    if (sw_rst_req && (r_state != S_RESET)) begin
      w_state       = S_HOLD;
      w_cnt         = '0;
      w_stage_rst_n = '0;
      w_cur_stage   = '0;
      w_rst_done    = 1'b0;
      w_busy        = 1'b1;
    end
  end

  assign stage_rst_n = r_stage_rst_n;
  assign rst_done    = r_rst_done;
  assign busy        = r_busy;
  assign cur_stage   = r_cur_stage;

endmodule

`default_nettype wire

// File: tb/tb_my_reset_sequencer.sv
// ============================================================================
// Module      : tb_my_reset_sequencer
// Description : Self-checking bench for my_reset_sequencer (default and edge
//               parameter instances) against an elapsed-time reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_my_reset_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       sw_rst_req;
  logic [2:0] stage0;
  logic       done0, busy0;
  logic [1:0] cur0;
  logic [0:0] stage1;
  logic       done1, busy1;
  logic [0:0] cur1;

  int n_tests = 0;
  int n_fail  = 0;
  int edge_n  = 0;

  // Reference model: per instance, edges since the rst fall and since E0.
  int p_sync [2] = '{2, 3};
  int p_hold [2] = '{16, 1};
  int p_gap  [2] = '{4, 4};
  int p_num  [2] = '{3, 1};
  bit e0v    [2];
  int since_fall [2];
  int since_e0   [2];

  always #5 clk = ~clk;

  my_reset_sequencer dut (
    .clk         (clk),
    .rst         (rst),
    .sw_rst_req  (sw_rst_req),
    .stage_rst_n (stage0),
    .rst_done    (done0),
    .busy        (busy0),
    .cur_stage   (cur0)
  );

  my_reset_sequencer #(
    .SYNC_STAGES (3),
    .HOLD_CYCLES (1),
    .GAP_CYCLES  (4),
    .NUM_STAGES  (1)
  ) dut_edge (
    .clk         (clk),
    .rst         (rst),
    .sw_rst_req  (sw_rst_req),
    .stage_rst_n (stage1),
    .rst_done    (done1),
    .busy        (busy1),
    .cur_stage   (cur1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at t=%0t edge=%0d: got %0h expected %0h", tag, $time, edge_n, got, exp);
    end
  endtask

  task automatic mdl_reset();
    for (int i = 0; i < 2; i++) begin
      e0v[i]        = 1'b0;
      since_fall[i] = 0;
      since_e0[i]   = 0;
    end
  endtask

  function automatic int exp_rel(input int i);
    int r;
    if (!e0v[i] || since_e0[i] < p_hold[i]) return 0;
    r = 1 + (since_e0[i] - p_hold[i]) / p_gap[i];
    return (r > p_num[i]) ? p_num[i] : r;
  endfunction

  task automatic check_all();
    int r0, r1;
    r0 = exp_rel(0);
    r1 = exp_rel(1);
    check("d0.stage", 32'(stage0), 32'((1 << r0) - 1));
    check("d0.cur",   32'(cur0),   32'(r0));
    check("d0.done",  32'(done0),  32'(r0 == 3));
    check("d0.busy",  32'(busy0),  32'(r0 != 3));
    check("d1.stage", 32'(stage1), 32'((1 << r1) - 1));
    check("d1.cur",   32'(cur1),   32'(r1));
    check("d1.done",  32'(done1),  32'(r1 == 1));
    check("d1.busy",  32'(busy1),  32'(r1 != 1));
  endtask

  task automatic step(input bit sw);
    sw_rst_req = sw;
    @(posedge clk);
    if (!rst) begin
      for (int i = 0; i < 2; i++) begin
        if (!e0v[i]) begin
          since_fall[i]++;
          if (since_fall[i] == p_sync[i] + 1) begin
            e0v[i]      = 1'b1;
            since_e0[i] = 0;
          end
        end else if (sw) begin
          since_e0[i] = 0;
        end else begin
          since_e0[i]++;
        end
      end
    end
    edge_n++;
    @(negedge clk);
    sw_rst_req = 1'b0;
    check_all();
  endtask

  task automatic run_to(input int n);
    while (edge_n < n) step(1'b0);
  endtask

  task automatic raise_rst();
    rst = 1'b1;
    mdl_reset();
    #1;
    check("async.stage", 32'(stage0), 32'd0);
    check("async.cur",   32'(cur0),   32'd0);
    check("async.busy",  32'(busy0),  32'd1);
    check_all();
  endtask

  task automatic drop_rst();
    rst    = 1'b0;
    edge_n = 0;
  endtask

  initial begin
    rst        = 1'b1;
    sw_rst_req = 1'b0;
    mdl_reset();

    // Power-on with a soft request while rst is high (must be ignored).
    for (int i = 0; i < 10; i++) step(i == 5);
    drop_rst();
    run_to(4);
    check("edge.e4.stage", 32'(stage1), 32'd0);
    run_to(5);
    check("edge.e5.stage", 32'(stage1), 32'd1);
    check("edge.e5.done",  32'(done1),  32'd1);
    check("edge.e5.cur",   32'(cur1),   32'd1);
    run_to(18);
    check("po.e18", 32'(stage0), 32'b000);
    run_to(19);
    check("po.e19", 32'(stage0), 32'b001);
    run_to(23);
    check("po.e23", 32'(stage0), 32'b011);
    run_to(26);
    check("po.e26.done", 32'(done0), 32'd0);
    run_to(27);
    check("po.e27",      32'(stage0), 32'b111);
    check("po.e27.done", 32'(done0),  32'd1);
    check("po.e27.busy", 32'(busy0),  32'd0);

    // Soft reset in S_DONE at edge 40.
    run_to(39);
    step(1'b1);
    check("sw40.stage", 32'(stage0), 32'b000);
    check("sw40.done",  32'(done0),  32'd0);
    run_to(55);
    check("sw.e55", 32'(stage0), 32'b000);
    run_to(56);
    check("sw.e56", 32'(stage0), 32'b001);
    run_to(60);
    check("sw.e60", 32'(stage0), 32'b011);
    run_to(64);
    check("sw.e64", 32'(stage0), 32'b111);

    // Raw reset mid-sequence at edge 21.
    raise_rst();
    step(1'b0);
    drop_rst();
    run_to(21);
    check("mid.e21", 32'(stage0), 32'b001);
    raise_rst();
    repeat (3) step(1'b0);
    drop_rst();
    run_to(18);
    check("mid.e18", 32'(stage0), 32'b000);
    run_to(19);
    check("mid.e19", 32'(stage0), 32'b001);
    run_to(27);
    check("mid.e27", 32'(stage0), 32'b111);

    // Soft reset during hold at edge 10.
    raise_rst();
    step(1'b0);
    drop_rst();
    run_to(9);
    step(1'b1);
    run_to(25);
    check("hold.e25", 32'(stage0), 32'b000);
    run_to(26);
    check("hold.e26", 32'(stage0), 32'b001);
    run_to(34);
    check("hold.e34", 32'(stage0), 32'b111);

    // Glitch of 0.3 clock period after rst_done.
    #1 rst = 1'b1;
    mdl_reset();
    #1;
    check("gl.stage", 32'(stage0), 32'd0);
    check("gl.done",  32'(done0),  32'd0);
    #2 drop_rst();
    run_to(18);
    check("gl.e18", 32'(stage0), 32'b000);
    run_to(19);
    check("gl.e19", 32'(stage0), 32'b001);
    run_to(30);

    // Randomized soft requests and raw resets of varying width.
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 299) == 0) begin
        int k;
        k = $urandom_range(0, 3);
        raise_rst();
        if (k == 0) begin
          #2 drop_rst();
        end else begin
          for (int j = 0; j < k; j++) step(1'($urandom_range(0, 1)));
          drop_rst();
        end
      end else begin
        step($urandom_range(0, 24) == 0);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/my_reset_sequencer.md
Name: my_reset_sequencer

Overview:
Consumes the free-running clock and raw reset from the bench clock/reset model and produces ordered, clean reset releases for the DUT and TB agents. Raw reset is asynchronous active-high. Its deassertion is synchronised, stretched by a hold period, and then released one reset domain at a time, with a fixed gap between domains. A synchronous soft-reset request replays the sequence without a raw reset.

Parameters:
SYNC_STAGES, 2, number of flops in the deassertion synchroniser (range 2..4).
HOLD_CYCLES, 16, clocks between FSM leaving reset and release of domain 0 (at least 1).
GAP_CYCLES, 4, clocks between releases of consecutive domains (at least 1).
NUM_STAGES, 3, number of reset domains sequenced (range 1..8).

Ports:
clk  input  1  free-running clock from the clock model.
rst  input  1  raw reset, asynchronous, active-high.
sw_rst_req  input  1  synchronous soft-reset request, single-cycle pulse.
stage_rst_n  output  NUM_STAGES  per-domain reset, active-low; bit k releases k-th.
rst_done  output  1  high once all domains are released.
busy  output  1  high whenever the sequence is not complete.
cur_stage  output  $clog2(NUM_STAGES+1)  number of domains currently released.

Behaviour:
- Interface: one clock, clk. rst is asynchronous, active-high. All state flops reset asynchronously on rst.
- Reset values: stage_rst_n = all 0, rst_done = 0, busy = 1, cur_stage = 0, FSM = S_RESET, counter = 0.
- Synchroniser:
  - rst high forces all synchroniser flops to 1 immediately.
  - On rst deassertion, a 0 shifts through the chain. rst_sync falls on edge SYNC_STAGES after the rst fall.
  - Edge 1 is the first rising edge after the rst fall.
- FSM states: S_RESET, S_HOLD, S_RELEASE, S_DONE.
- S_RESET → S_HOLD: on the first edge at which rst_sync is sampled low, i.e. edge SYNC_STAGES+1. Call this edge E0; the counter clears at E0.
- S_HOLD:
  - Counter increments each clock.
  - At edge E0+HOLD_CYCLES: stage_rst_n[0] goes to 1, cur_stage goes to 1, counter clears.
  - Next state is S_RELEASE, or S_DONE when NUM_STAGES = 1.
- S_RELEASE:
  - Domain k releases at edge E0+HOLD_CYCLES+k×GAP_CYCLES; cur_stage increments with each release.
  - The edge releasing domain NUM_STAGES-1 also sets rst_done = 1, busy = 0, and moves to S_DONE.
- Release order is monotonic: a bit of stage_rst_n never rises before a lower-indexed bit. Once released, a bit stays 1 until a reset or soft reset.
- Defaults timeline (SYNC=2, HOLD=16, GAP=4, NUM=3): domain 0 at edge 19, domain 1 at edge 23, domain 2 and rst_done at edge 27.
- Soft reset (sw_rst_req sampled high in S_HOLD, S_RELEASE or S_DONE):
  - At that edge: stage_rst_n = 0, rst_done = 0, busy = 1, cur_stage = 0, counter clears, FSM goes to S_HOLD. That edge becomes the new E0.
  - A request in S_HOLD restarts the hold count.
  - A request in S_RESET is ignored.
  - Back-to-back requests keep restarting from E0.
- Raw reset mid-sequence: rst high in any state returns all outputs to reset values asynchronously, with no wait for clk. Sequencing resumes only after a new synchronised deassertion.
- Glitch handling: a rst pulse shorter than one clock period still resets the synchroniser, so deassertion latency restarts from the rst fall.
- Counter width: $clog2(max(HOLD_CYCLES, GAP_CYCLES)+1). Compare with ==, never with wrap; the counter never overflows.
- All outputs are registered, with no combinational path from inputs.

Decomposition:
- Shared package my_tb_pkg holds:
  - typedef enum logic [1:0] rst_seq_state_e {S_RESET, S_HOLD, S_RELEASE, S_DONE};
  - localparams for the default values of SYNC_STAGES, HOLD_CYCLES, GAP_CYCLES and NUM_STAGES.
- Sub-module my_reset_sync: parameter SYNC_STAGES; ports clk, rst, rst_sync. It is instantiated once.
- Elaboration assertions check parameter ranges.

Test Plan:
- Power-on with defaults: rst high for 10 clocks, then low → stage_rst_n goes 001 at edge 19, 011 at edge 23, 111 at edge 27. rst_done rises at edge 27; busy falls at edge 27.
- Raw reset mid-sequence: assert rst at edge 21 (stage_rst_n = 001) → stage_rst_n = 000, cur_stage = 0, busy = 1 before the next edge. After release, the full default timeline repeats from the new rst fall.
- Soft reset in S_DONE: pulse sw_rst_req at edge 40 → stage_rst_n = 000, rst_done = 0 at edge 40. Domain 0 releases at 56, domain 1 at 60, domain 2 at 64.
- Soft reset during hold and in S_RESET:
  - Pulse at edge 10 (in S_HOLD) → domain 0 releases at edge 26.
  - Pulse while rst is high → no effect; the timeline is unchanged.
- Short glitch: rst pulse of 0.3 period after rst_done → outputs reset immediately. Domain 0 releases 19 edges after the glitch falls.
- Edge parameters: NUM_STAGES=1, HOLD_CYCLES=1, SYNC_STAGES=3 → stage_rst_n[0] and rst_done both rise at edge 5; cur_stage = 1.
